hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Stall and flush controller for the 5-stage MIPS pipeline; works opposite the forwarding unit.
- The forwarding unit serves consumers by bypassing producer results. This block holds consumers back when no bypass can supply the operand in time (load-use, or any RAW hazard when forwarding is disabled).
- It also squashes wrong-path instructions when a branch resolves taken in MEM.
- It keeps its own shadow copy of destination and control bits for the EX, MEM and WB stages and drives the PC/IF-ID write enables, bubble and flush controls.

Parameters:
- FWD_EN, 1, 1 = forwarding present: stall only on load-use; 0 = stall until the producer has left WB.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_valid  in  1  IF/ID holds a real instruction
- id_rs  in  5  rs field (instr[25:21]) of the instruction in ID
- id_rt  in  5  rt field (instr[20:16]) of the instruction in ID
- id_uses_rt  in  1  the instruction in ID reads rt (R-type, sw, beq)
- id_reg_write  in  1  the instruction in ID writes a register
- id_mem_read  in  1  the instruction in ID is a load
- id_dst  in  5  destination register selected in ID (rd or rt)
- branch_taken  in  1  branch resolved taken in MEM this cycle
- pc_write  out  1  PC may load its next value
- if_id_write  out  1  IF/ID may load
- id_ex_bubble  out  1  load a NOP (all control bits 0) into ID/EX
- if_id_flush  out  1  clear IF/ID
- id_ex_flush  out  1  clear ID/EX
- ex_mem_flush  out  1  clear EX/MEM
- state  out  2  00 RUN, 01 STALL, 10 FLUSH
- stall_cycles  out  CNT_W  cycles with id_ex_bubble=1, saturating
- flush_events  out  CNT_W  count of taken-branch flushes, saturating

Behaviour:
- Reset (async, any time including mid-stall): shadow entries EX/MEM/WB invalid, state=RUN, counters=0.
- Output values during reset: pc_write=1, if_id_write=1, all bubble and flush outputs 0.
- Shadow entry: {valid, reg_write, mem_read, dst}.
- A match against an entry requires: valid=1, reg_write=1, dst!=0, and (dst==id_rs, or id_uses_rt and dst==id_rt).
- ID is checked only when id_valid=1 and state!=FLUSH. In the cycle after a flush, ID holds a squashed slot and is treated as empty.
- Hazard when FWD_EN=1: the EX entry matches and has mem_read=1.
- Hazard when FWD_EN=0: any of the EX, MEM or WB entries matches. The register file is not write-through, so a WB producer still stalls.
- Outputs are combinational from state, shadow and inputs, resolved in this priority order:
  1. branch_taken=1: if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0. Any pending hazard is dropped.
  2. hazard: pc_write=0, if_id_write=0, id_ex_bubble=1, all flushes 0.
  3. otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- Shadow update at posedge clk:
  - branch_taken: EX<=invalid, MEM<=invalid, WB<=MEM (the branch itself drains).
  - hazard: EX<=invalid (the bubble), MEM<=EX, WB<=MEM.
  - otherwise: EX<={id_valid, id_reg_write, id_mem_read, id_dst}, MEM<=EX, WB<=MEM.
- FSM, registered:
  - RUN -> STALL on hazard; RUN -> FLUSH on branch_taken.
  - STALL -> STALL while the hazard persists; STALL -> RUN when it clears; STALL -> FLUSH on branch_taken.
  - FLUSH -> RUN, unless branch_taken is set again (then FLUSH -> FLUSH).
- Stall latency:
  - FWD_EN=1: a load-use pair stalls exactly 1 cycle.
  - FWD_EN=0: a back-to-back dependency stalls 3 cycles; a producer 2 ahead stalls 2; a producer 3 ahead stalls 1.
- Counters: stall_cycles increments on each posedge where id_ex_bubble=1; flush_events increments on each posedge where branch_taken=1. Both saturate at all-ones.

Test Plan:
- FWD_EN=1, lw $2 then add $3,$2,$4: exactly 1 cycle with pc_write=0 and id_ex_bubble=1, state RUN->STALL->RUN, stall_cycles=1.
- FWD_EN=0, add $2,$1,$1 then sub $5,$2,$6: 3 consecutive bubble cycles, then sub issues; stall_cycles=3. Repeat with one independent instruction between: 2 cycles.
- Producer dst=$0, or id_uses_rt=0 with an rt match only: no stall; pc_write stays 1.
- Branch during stall: hazard active and branch_taken=1 in the same cycle. All three flushes=1, id_ex_bubble=0, state->FLUSH; next cycle id_valid=1 with a matching rs gives no stall; flush_events=1.
- Reset mid-stall, asserted asynchronously between edges: outputs go to pc_write=1 and bubble=0 immediately, state=RUN, counters=0; a dependent instruction after reset sees an empty shadow and does not stall.
- Saturation: 70000 forced load-use stalls, then stall_cycles=16'hFFFF and it holds there.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline.
// Tracks EX/MEM/WB destinations and holds or squashes ID/IF.
module hazard_stall_unit #(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [4:0]       id_dst,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] dst;
    } shadow_t;

    state_t state_q, state_d;
    shadow_t ex_q, ex_d;
    shadow_t mem_q, mem_d;
    shadow_t wb_q, wb_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic check;
    logic hazard;
    logic br;

    function automatic logic hit(input shadow_t e,
                                 input logic [4:0] rs,
                                 input logic [4:0] rt,
                                 input logic use_rt);
        return e.valid && e.reg_write && (e.dst != 5'd0) &&
               ((e.dst == rs) || (use_rt && (e.dst == rt)));
    endfunction

    // Hazard detection against the shadow pipeline.
    // A slot right after a flush is squashed, so ID is ignored then.
    always_comb begin
        check  = id_valid && (state_q != FLUSH);
        hazard = 1'b0;
        if (check) begin
            if (FWD_EN != 0) begin
                hazard = hit(ex_q, id_rs, id_rt, id_uses_rt) &&
                         ex_q.mem_read;
            end else begin
                hazard = hit(ex_q, id_rs, id_rt, id_uses_rt) ||
                         hit(mem_q, id_rs, id_rt, id_uses_rt) ||
                         hit(wb_q, id_rs, id_rt, id_uses_rt);
            end
        end
        hazard = hazard && !reset;
        br     = branch_taken && !reset;
    end

    // Pipeline control outputs; a taken branch overrides any stall.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (br) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Next shadow contents, FSM state and saturating counters.
    always_comb begin
        ex_d    = '{valid: id_valid, reg_write: id_reg_write,
                    mem_read: id_mem_read, dst: id_dst};
        mem_d   = ex_q;
        wb_d    = mem_q;
        state_d = RUN;
        stall_d = stall_q;
        flush_d = flush_q;
        if (br) begin
            ex_d  = '0;
            mem_d = '0;
        end else if (hazard) begin
            ex_d = '0;
        end
        unique case (state_q)
            RUN, STALL: begin
                if (br)          state_d = FLUSH;
                else if (hazard) state_d = STALL;
                else             state_d = RUN;
            end
            FLUSH: begin
                state_d = br ? FLUSH : RUN;
            end
            default: state_d = RUN;
        endcase
        if (id_ex_bubble && (stall_q != '1))
            stall_d = stall_q + 1'b1;
        if (br && (flush_q != '1))
            flush_d = flush_q + 1'b1;
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule
